// File: rtl/ascon_ise_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ascon_ise_pipe : pipelined Ascon rotate / logic / sigma ISE unit  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module ascon_ise_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [5:0]      req_imm_a,
  input  logic [5:0]      req_imm_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rd,
  output logic            rsp_err
);

  localparam logic [2:0] OP_ROR_L   = 3'd0;
  localparam logic [2:0] OP_ROR_H   = 3'd1;
  localparam logic [2:0] OP_ORNOT   = 3'd2;
  localparam logic [2:0] OP_ANDNOT  = 3'd3;
  localparam logic [2:0] OP_XNOR    = 3'd4;
  localparam logic [2:0] OP_SIGMA_L = 3'd5;
  localparam logic [2:0] OP_SIGMA_H = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  localparam int PKT_W = 3 + 3 + 3 + 64 + XLEN + 64 + 64;

  function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
    return (x >> n) | (x << (7'd64 - {1'b0, n}));
  endfunction

  logic [63:0]      req_w;
  logic [PKT_W-1:0] req_pkt;
  logic [PKT_W-1:0] s2_pkt;
  logic             s2_valid;
  logic             out_adv;

  logic [2:0]       s2_op;
  logic [2:0]       s2_a_hi;
  logic [2:0]       s2_b_hi;
  logic [63:0]      s2_w;
  logic [XLEN-1:0]  s2_rs2;
  logic [63:0]      s2_ra_p;
  logic [63:0]      s2_rb_p;

  logic             rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rsp_rd_q, rsp_rd_d;
  logic             rsp_err_q, rsp_err_d;

  generate
    if (XLEN == 32) begin : g_w_pair
      assign req_w = {req_rs2, req_rs1};
    end else begin : g_w_native
      assign req_w = req_rs1;
    end
  endgenerate

  // Front half of both rotations: only amount bits [2:0] are applied here.
  assign req_pkt = {req_op, req_imm_a[5:3], req_imm_b[5:3], req_w, req_rs2,
                    ror64(req_w, {3'b000, req_imm_a[2:0]}),
                    ror64(req_w, {3'b000, req_imm_b[2:0]})};

  assign out_adv = !rsp_valid_q || rsp_ready;

  generate
    if (STAGES == 2) begin : g_pipe2
      logic             s1_valid_q, s1_valid_d;
      logic [PKT_W-1:0] s1_pkt_q, s1_pkt_d;
      logic             s1_adv;

      always_comb begin
        s1_adv     = !s1_valid_q || out_adv;
        s1_valid_d = s1_adv ? req_valid : s1_valid_q;
        s1_pkt_d   = s1_pkt_q;
        if (s1_adv && req_valid) s1_pkt_d = req_pkt;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid_q <= 1'b0;
          s1_pkt_q   <= '0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_pkt_q   <= s1_pkt_d;
        end
      end

      assign req_ready = s1_adv;
      assign s2_valid  = s1_valid_q;
      assign s2_pkt    = s1_pkt_q;
    end else begin : g_pipe1
      assign req_ready = out_adv;
      assign s2_valid  = req_valid;
      assign s2_pkt    = req_pkt;
    end
  endgenerate

  assign {s2_op, s2_a_hi, s2_b_hi, s2_w, s2_rs2, s2_ra_p, s2_rb_p} = s2_pkt;

  logic [63:0]     ra, rb, sig;
  logic [XLEN-1:0] rs1, res;
  logic            illegal;

  always_comb begin
    ra      = ror64(s2_ra_p, {s2_a_hi, 3'b000});
    rb      = ror64(s2_rb_p, {s2_b_hi, 3'b000});
    sig     = s2_w ^ ra ^ rb;
    rs1     = s2_w[XLEN-1:0];
    illegal = (s2_op == OP_RSVD) ||
              ((XLEN == 64) && ((s2_op == OP_ROR_H) || (s2_op == OP_SIGMA_H)));
    case (s2_op)
      OP_ROR_L:   res = ra[XLEN-1:0];
      OP_ROR_H:   res = XLEN'(ra[63:32]);
      OP_ORNOT:   res = rs1 | ~s2_rs2;
      OP_ANDNOT:  res = rs1 & ~s2_rs2;
      OP_XNOR:    res = ~(rs1 ^ s2_rs2);
      OP_SIGMA_L: res = sig[XLEN-1:0];
      OP_SIGMA_H: res = XLEN'(sig[63:32]);
      default:    res = '0;
    endcase
    if (illegal) res = '0;

    rsp_valid_d = out_adv ? s2_valid : rsp_valid_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_err_d   = rsp_err_q;
    if (out_adv && s2_valid) begin
      rsp_rd_d  = res;
      rsp_err_d = illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ascon_ise_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ascon_ise_pipe : two configurations (32/1 and 64/2) vs model   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ascon_ise_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  vld, rr;
  logic [2:0]  op  [2];
  logic [63:0] rs1 [2];
  logic [63:0] rs2 [2];
  logic [5:0]  ia  [2];
  logic [5:0]  ib  [2];
  wire  [1:0]  rdy, rv, er;
  wire  [31:0] rd0;
  wire  [63:0] rd1;

  always #5 clk = ~clk;

  ascon_ise_pipe #(.XLEN(32), .STAGES(1)) u_d0 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_op(op[0]),
    .req_rs1(rs1[0][31:0]), .req_rs2(rs2[0][31:0]), .req_imm_a(ia[0]), .req_imm_b(ib[0]),
    .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_rd(rd0), .rsp_err(er[0]));

  ascon_ise_pipe #(.XLEN(64), .STAGES(2)) u_d1 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_op(op[1]),
    .req_rs1(rs1[1]), .req_rs2(rs2[1]), .req_imm_a(ia[1]), .req_imm_b(ib[1]),
    .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_rd(rd1), .rsp_err(er[1]));

  typedef struct {
    logic [63:0] rd;
    logic        err;
    int          cyc;
    int          id;
  } exp_t;

  exp_t        q0[$], q1[$];
  int          n_chk = 0, n_fail = 0, cyc = 0, next_id = 0;
  int          last_id [2];
  logic [63:0] last_rd [2];
  logic        last_err [2];
  logic [1:0]  acc;
  bit          chk_lat;

  // Reference: rotate one bit at a time, then apply the opcode table.
  function automatic logic [63:0] rot(input logic [63:0] w, input logic [5:0] n);
    logic [63:0] r = w;
    for (int k = 0; k < int'(n); k++) r = {r[0], r[63:1]};
    return r;
  endfunction

  function automatic logic [64:0] model(input int xl, input logic [2:0] o,
      input logic [63:0] a1, input logic [63:0] a2, input logic [5:0] a, input logic [5:0] b);
    logic [63:0] w, m, r;
    m = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    w = (xl == 32) ? {a2[31:0], a1[31:0]} : a1;
    case (o)
      3'd0: r = rot(w, a) & m;
      3'd1: if (xl == 64) return {1'b1, 64'd0}; else r = rot(w, a) >> 32;
      3'd2: r = (a1 | ~a2) & m;
      3'd3: r = (a1 & ~a2) & m;
      3'd4: r = ~(a1 ^ a2) & m;
      3'd5: r = (w ^ rot(w, a) ^ rot(w, b)) & m;
      3'd6: if (xl == 64) return {1'b1, 64'd0}; else r = (w ^ rot(w, a) ^ rot(w, b)) >> 32;
      default: return {1'b1, 64'd0};
    endcase
    return {1'b0, r};
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic logic [63:0] get_rd(input int i);
    return (i == 0) ? {32'd0, rd0} : rd1;
  endfunction

  task automatic tick();
    exp_t        e;
    logic [64:0] m;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rv[i]) begin
        n_chk++;
        assert (qsize(i) > 0) else begin
          n_fail++; $error("FAIL spurious_rsp dut%0d: rsp_valid=1 required 0", i);
        end
        if (qsize(i) > 0) begin
          e = qfront(i);
          n_chk++;
          assert (get_rd(i) === e.rd && er[i] === e.err) else begin
            n_fail++;
            $error("FAIL rsp_data dut%0d id%0d: got rd=%h err=%b required rd=%h err=%b",
                   i, e.id, get_rd(i), er[i], e.rd, e.err);
          end
          if (chk_lat && e.id != last_id[i]) begin
            n_chk++;
            assert (cyc == e.cyc + i + 1) else begin
              n_fail++;
              $error("FAIL latency dut%0d id%0d: got %0d cycles required %0d", i, e.id, cyc - e.cyc, i + 1);
            end
          end
          last_id[i] = e.id;
          if (rr[i]) begin
            if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            last_rd[i]  = e.rd;
            last_err[i] = e.err;
          end
        end
      end else begin
        n_chk++;
        assert (get_rd(i) === last_rd[i] && er[i] === last_err[i]) else begin
          n_fail++;
          $error("FAIL rsp_hold dut%0d: got rd=%h err=%b required rd=%h err=%b",
                 i, get_rd(i), er[i], last_rd[i], last_err[i]);
        end
      end
      acc[i] = vld[i] & rdy[i];
      if (acc[i]) begin
        m = model((i == 0) ? 32 : 64, op[i], rs1[i], rs2[i], ia[i], ib[i]);
        e.rd = m[63:0]; e.err = m[64]; e.cyc = cyc; e.id = next_id++;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int i, input logic [2:0] o, input logic [63:0] a1,
                      input logic [63:0] a2, input logic [5:0] a, input logic [5:0] b,
                      output int tries);
    vld = '0; vld[i] = 1'b1;
    op[i] = o; rs1[i] = a1; rs2[i] = a2; ia[i] = a; ib[i] = b;
    tries = 0;
    do begin tick(); tries++; end while (!acc[i] && tries < 50);
    n_chk++;
    assert (acc[i] === 1'b1) else begin
      n_fail++; $error("FAIL accept_timeout dut%0d: accepted=%b required 1", i, acc[i]);
    end
    vld[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    vld = '0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int k = 0;
    vld = '0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 100) begin tick(); k++; end
    n_chk++;
    assert (q0.size() == 0 && q1.size() == 0) else begin
      n_fail++; $error("FAIL drain: got %0d/%0d outstanding required 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    int t;
    vld = '0; rr = '1; chk_lat = 1'b1;
    for (int i = 0; i < 2; i++) begin
      op[i] = '0; rs1[i] = '0; rs2[i] = '0; ia[i] = '0; ib[i] = '0;
      last_id[i] = -1; last_rd[i] = '0; last_err[i] = 1'b0;
    end

    #3;
    n_chk++;
    assert (rv === 2'b00 && rd0 === 32'd0 && rd1 === 64'd0 && er === 2'b00) else begin
      n_fail++; $error("FAIL reset_state: got rv=%b rd0=%h rd1=%h err=%b required all 0", rv, rd0, rd1, er);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    assert (rdy === 2'b11) else begin
      n_fail++; $error("FAIL ready_after_reset: got %b required 11", rdy);
    end
    @(negedge clk);

    // Directed cases on the 32-bit single-stage unit.
    send(0, 3'd0, 64'h0000_0001, 64'h8000_0000, 6'd1, 6'd0, t);
    send(0, 3'd1, 64'h0000_0001, 64'h8000_0000, 6'd1, 6'd0, t);
    send(0, 3'd0, 64'h1111_1111, 64'h2222_2222, 6'd32, 6'd0, t);
    send(0, 3'd0, 64'h1111_1111, 64'h2222_2222, 6'd0, 6'd0, t);
    send(0, 3'd2, 64'h0000_FFFF, 64'h00FF_00FF, 6'd0, 6'd0, t);
    send(0, 3'd3, 64'h0000_FFFF, 64'h00FF_00FF, 6'd0, 6'd0, t);
    send(0, 3'd4, 64'h0000_FFFF, 64'h00FF_00FF, 6'd0, 6'd0, t);
    send(0, 3'd5, 64'h0000_0001, 64'h0000_0000, 6'd19, 6'd28, t);
    send(0, 3'd6, 64'h0000_0001, 64'h0000_0000, 6'd19, 6'd28, t);
    send(0, 3'd7, 64'h1234_5678, 64'h9ABC_DEF0, 6'd5, 6'd9, t);
    // Directed cases on the 64-bit two-stage unit.
    send(1, 3'd5, 64'd1, 64'd0, 6'd19, 6'd28, t);
    send(1, 3'd6, 64'd1, 64'd0, 6'd19, 6'd28, t);
    send(1, 3'd7, 64'd1, 64'd0, 6'd19, 6'd28, t);
    send(1, 3'd0, 64'h0123_4567_89AB_CDEF, 64'd0, 6'd63, 6'd0, t);
    send(1, 3'd4, 64'h0000_FFFF_0000_FFFF, 64'h00FF_00FF_00FF_00FF, 6'd0, 6'd0, t);
    drain();

    // Back-to-back stream: every request accepted on its first cycle.
    for (int k = 0; k < 8; k++) begin
      send(1, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
           6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), t);
      n_chk++;
      assert (t == 1) else begin
        n_fail++; $error("FAIL stream_bubble k%0d: got %0d tries required 1", k, t);
      end
    end
    drain();

    // Stall: two requests fill the pipe, the third is refused until release.
    chk_lat = 1'b0;
    rr[1] = 1'b0;
    send(1, 3'd5, {$urandom, $urandom}, 64'd0, 6'd19, 6'd28, t);
    send(1, 3'd2, {$urandom, $urandom}, {$urandom, $urandom}, 6'd0, 6'd0, t);
    vld[1] = 1'b1; op[1] = 3'd0; rs1[1] = {$urandom, $urandom}; ia[1] = 6'd13;
    repeat (3) begin
      tick();
      n_chk++;
      assert (acc[1] === 1'b0 && rdy[1] === 1'b0) else begin
        n_fail++; $error("FAIL stall_ready: got req_ready=%b required 0", rdy[1]);
      end
    end
    rr[1] = 1'b1;
    send(1, op[1], rs1[1], rs2[1], ia[1], ib[1], t);
    drain();

    // Randomised traffic with random backpressure on both units.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 2; i++) begin
        vld[i] = ($urandom_range(0, 3) != 0);
        rr[i]  = ($urandom_range(0, 3) != 0);
        op[i]  = 3'($urandom_range(0, 7));
        rs1[i] = {$urandom, $urandom};
        rs2[i] = {$urandom, $urandom};
        ia[i]  = 6'($urandom_range(0, 63));
        ib[i]  = 6'($urandom_range(0, 63));
      end
      tick();
    end
    rr = '1;
    drain();

    // Asynchronous reset with two requests in flight.
    rr[1] = 1'b0;
    send(1, 3'd4, {$urandom, $urandom}, {$urandom, $urandom}, 6'd0, 6'd0, t);
    send(1, 3'd0, {$urandom, $urandom}, 64'd0, 6'd7, 6'd0, t);
    #1;
    n_chk++;
    assert (rv[1] === 1'b1) else begin
      n_fail++; $error("FAIL inflight_valid: got rsp_valid=%b required 1", rv[1]);
    end
    #1 rst = 1'b1;
    #1;
    n_chk++;
    assert (rv === 2'b00 && rd1 === 64'd0 && er === 2'b00) else begin
      n_fail++; $error("FAIL async_reset: got rv=%b rd1=%h err=%b required 0", rv, rd1, er);
    end
    q0.delete(); q1.delete();
    for (int i = 0; i < 2; i++) begin last_rd[i] = '0; last_err[i] = 1'b0; end
    @(negedge clk);
    rst = 1'b0;
    rr = '1;
    idle(8);
    #1;
    n_chk++;
    assert (rdy === 2'b11) else begin
      n_fail++; $error("FAIL ready_post_reset: got %b required 11", rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
